// File: rtl/nco_phase_gen.sv
// Sample-clock divider and phase accumulator for the sine ROM / DAC path.
// addr advances by the synchronised switch word on each divclk falling edge.
module nco_phase_gen #(
    parameter int CLK_DIV = 5000,
    parameter int PHASE_W = 10,
    parameter int ADDR_W  = 10
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              EN,
    input  logic [9:0]        SW,
    output logic [ADDR_W-1:0] addr,
    output logic              divclk,
    output logic              sample_tick,
    output logic              wrap
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_UPD  = CNT_W'(CLK_DIV / 2 - 1);

    logic [CNT_W-1:0]   count_q, count_d;
    logic               divclk_q, divclk_d;
    logic               sample_tick_q, sample_tick_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [9:0]         sw_s1_q, sw_s2_q;
    logic               update;
    logic [PHASE_W:0]   sum;

    // Modular add; the extra MSB is the carry that drives wrap.
    function automatic logic [PHASE_W:0] phase_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
        phase_add = {1'b0, a} + {1'b0, b};
    endfunction

    always_comb begin
        count_d       = count_q;
        divclk_d      = divclk_q;
        sample_tick_d = 1'b0;
        wrap_d        = 1'b0;
        inc_d         = inc_q;
        phase_d       = phase_q;
        update        = EN && (count_q == CNT_UPD);
        sum           = '0;

        if (EN) begin
            count_d       = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
            divclk_d      = (count_d < CNT_HALF);
            sample_tick_d = (count_d == '0);
        end

        // The freshly captured increment is the one added on this update.
        if (update) begin
            inc_d   = PHASE_W'(sw_s2_q);
            sum     = phase_add(phase_q, inc_d);
            phase_d = sum[PHASE_W-1:0];
            wrap_d  = sum[PHASE_W];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            count_q       <= CNT_LAST;
            divclk_q      <= 1'b0;
            sample_tick_q <= 1'b0;
            wrap_q        <= 1'b0;
            phase_q       <= '0;
            inc_q         <= '0;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
        end else begin
            count_q       <= count_d;
            divclk_q      <= divclk_d;
            sample_tick_q <= sample_tick_d;
            wrap_q        <= wrap_d;
            phase_q       <= phase_d;
            inc_q         <= inc_d;
            sw_s1_q       <= SW;
            sw_s2_q       <= sw_s1_q;
        end
    end

    assign addr        = phase_q[PHASE_W-1 -: ADDR_W];
    assign divclk      = divclk_q;
    assign sample_tick = sample_tick_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed and random bench for nco_phase_gen: cycle model feeds a scoreboard
// queue, plus inline checks of the headline values for each scenario.
module tb_nco_phase_gen;

    localparam int CLK_DIV = 10;
    localparam int PHASE_W = 10;
    localparam int ADDR_W  = 10;

    logic              CLOCK_50 = 1'b0;
    logic              RESET    = 1'b1;
    logic              EN       = 1'b0;
    logic [9:0]        SW       = '0;
    logic [ADDR_W-1:0] addr;
    logic              divclk;
    logic              sample_tick;
    logic              wrap;

    nco_phase_gen #(.CLK_DIV(CLK_DIV), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .EN         (EN),
        .SW         (SW),
        .addr       (addr),
        .divclk     (divclk),
        .sample_tick(sample_tick),
        .wrap       (wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              div;
        logic              tick;
        logic              wrap;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    int         m_cnt;
    int         m_phase;
    int         m_inc;
    logic [9:0] m_s1, m_s2;
    logic       m_div, m_tick, m_wrap;

    task automatic model_reset();
        m_cnt   = CLK_DIV - 1;
        m_phase = 0;
        m_inc   = 0;
        m_s1    = '0;
        m_s2    = '0;
        m_div   = 1'b0;
        m_tick  = 1'b0;
        m_wrap  = 1'b0;
    endtask

    // Advance the reference by one clock using the inputs now applied,
    // queue its expected outputs, then let the DUT take the edge.
    task automatic step();
        exp_t e;
        int   nc;
        int   s;
        logic upd;
        upd = EN && (m_cnt == CLK_DIV / 2 - 1);
        nc  = EN ? (m_cnt + 1) % CLK_DIV : m_cnt;
        m_wrap = 1'b0;
        if (upd) begin
            m_inc   = int'(m_s2);
            s       = m_phase + m_inc;
            m_phase = s % (1 << PHASE_W);
            m_wrap  = (s >= (1 << PHASE_W));
        end
        m_tick = 1'b0;
        if (EN) begin
            m_div  = (nc < CLK_DIV / 2);
            m_tick = (nc == 0);
        end
        m_cnt = nc;
        m_s2  = m_s1;
        m_s1  = SW;
        e.addr = ADDR_W'(m_phase);
        e.div  = m_div;
        e.tick = m_tick;
        e.wrap = m_wrap;
        sbq.push_back(e);
        @(posedge CLOCK_50);
        #1;
    endtask

    always @(negedge CLOCK_50) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            n_vec++;
            if ({addr, divclk, sample_tick, wrap} !== mon_e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got addr=%h div=%b tick=%b wrap=%b want addr=%h div=%b tick=%b wrap=%b",
                         $time, addr, divclk, sample_tick, wrap, mon_e.addr, mon_e.div, mon_e.tick, mon_e.wrap);
            end
        end
    end

    task automatic reset_dut(input logic [9:0] sw_val);
        @(negedge CLOCK_50);
        #1;
        RESET = 1'b1;
        EN    = 1'b0;
        SW    = sw_val;
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        RESET = 1'b0;
        EN    = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut(10'h123);
        n_vec++;
        if ({addr, divclk, sample_tick, wrap} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0", {addr, divclk, sample_tick, wrap});
        end
        for (int i = 0; i < 8; i++) step();
        n_vec++;
        if (addr !== 10'h123 || divclk !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_setup got addr=%h div=%b want addr=123 div=0", addr, divclk);
        end
        @(negedge CLOCK_50);
        #1;
        RESET = 1'b1;
        #1;
        n_vec++;
        if ({addr, divclk, sample_tick, wrap} !== 13'd0) begin
            n_bad++;
            $display("FAIL async_reset got addr=%h div=%b tick=%b wrap=%b want all 0", addr, divclk, sample_tick, wrap);
        end
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
        RESET = 1'b0;
        EN    = 1'b1;
        step();
        n_vec++;
        if (divclk !== 1'b1 || sample_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL first_edge got div=%b tick=%b want div=1 tick=1", divclk, sample_tick);
        end
    endtask

    task automatic test_step();
        int   ticks;
        int   highs;
        int   bad_chg;
        logic prev_div;
        logic [ADDR_W-1:0] prev_addr;
        reset_dut(10'h001);
        ticks = 0; highs = 0; bad_chg = 0;
        prev_div  = divclk;
        prev_addr = addr;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sample_tick) ticks++;
            if (divclk) highs++;
            if (addr !== prev_addr && !(prev_div && !divclk)) bad_chg++;
            prev_div  = divclk;
            prev_addr = addr;
        end
        n_vec++;
        if (addr !== 10'd4) begin
            n_bad++;
            $display("FAIL step_addr got %h want 004", addr);
        end
        n_vec++;
        if (ticks !== 4 || highs !== 20) begin
            n_bad++;
            $display("FAIL step_duty got ticks=%0d high=%0d want ticks=4 high=20", ticks, highs);
        end
        n_vec++;
        if (bad_chg !== 0) begin
            n_bad++;
            $display("FAIL step_addr_edge got %0d off-edge changes want 0", bad_chg);
        end
    endtask

    task automatic test_wrap();
        reset_dut(10'h200);
        for (int i = 0; i < 6; i++) step();
        n_vec++;
        if (addr !== 10'h200) begin
            n_bad++;
            $display("FAIL wrap_setup got %h want 200", addr);
        end
        SW = 10'h300;
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (addr !== 10'h100 || wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_first got addr=%h wrap=%b want addr=100 wrap=1", addr, wrap);
        end
        step();
        n_vec++;
        if (wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_pulse got wrap=%b want 0", wrap);
        end
        for (int i = 0; i < 9; i++) step();
        n_vec++;
        if (addr !== 10'h000 || wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_second got addr=%h wrap=%b want addr=000 wrap=1", addr, wrap);
        end
    endtask

    task automatic test_sw_change();
        reset_dut(10'h001);
        for (int i = 0; i < 15; i++) step();
        SW = 10'h010;
        step();
        n_vec++;
        if (addr !== 10'h002) begin
            n_bad++;
            $display("FAIL sw_late got %h want 002", addr);
        end
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (addr !== 10'h012) begin
            n_bad++;
            $display("FAIL sw_next got %h want 012", addr);
        end
    endtask

    task automatic test_en_hold();
        reset_dut(10'h005);
        for (int i = 0; i < 14; i++) step();
        EN = 1'b0;
        for (int i = 0; i < 23; i++) begin
            step();
            n_vec++;
            if ({addr, divclk, sample_tick, wrap} !== {10'h005, 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL en_hold cyc=%0d got addr=%h div=%b tick=%b wrap=%b want addr=005 div=1 tick=0 wrap=0",
                         i, addr, divclk, sample_tick, wrap);
            end
        end
        EN = 1'b1;
        step();
        n_vec++;
        if (addr !== 10'h005) begin
            n_bad++;
            $display("FAIL en_resume1 got %h want 005", addr);
        end
        step();
        n_vec++;
        if (addr !== 10'h00a) begin
            n_bad++;
            $display("FAIL en_resume2 got %h want 00a", addr);
        end
    endtask

    task automatic test_sw_zero();
        int ticks;
        int bad;
        reset_dut(10'h007);
        for (int i = 0; i < 6; i++) step();
        SW = 10'h000;
        ticks = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sample_tick) ticks++;
            if (addr !== 10'h007 || wrap !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0 || ticks !== 5) begin
            n_bad++;
            $display("FAIL sw_zero got bad=%0d ticks=%0d want bad=0 ticks=5", bad, ticks);
        end
    endtask

    task automatic test_random();
        reset_dut(10'($urandom));
        for (int i = 0; i < 300; i++) begin
            SW = 10'($urandom);
            EN = ($urandom_range(0, 3) != 0);
            step();
        end
        EN = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_step();
        test_wrap();
        test_sw_change();
        test_en_hold();
        test_sw_zero();
        test_random();
        @(negedge CLOCK_50);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
